// File: rtl/memory_stage_unit.sv
// MEM stage: drives load/store/stack beats to word memory; MEM/WB regs update 1 cycle after the last beat.
// Backpressure: Stall holds upstream while a beat waits for mem_ready; TIMEOUT waits abort with sticky Mem_Error.

module memory_stage_unit #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MR,
  input  logic              MW,
  input  logic              WB,
  input  logic              JWSP,
  input  logic              Stack_PC,
  input  logic              Stack_Flags,
  input  logic [2:0]        WB_Address,
  input  logic [31:0]       Data,
  input  logic [31:0]       Address,
  input  logic [2:0]        Final_Flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              Stall,
  output logic              WB_Out,
  output logic [2:0]        WB_Address_Out,
  output logic [15:0]       WB_Data,
  output logic [2:0]        Flags_From_Memory,
  output logic              Flags_Load,
  output logic [31:0]       PC_From_Memory,
  output logic              PC_Load,
  output logic              Mem_Error
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Operation captured at issue; later beats are driven only from these.
  logic                rd_q, we_q, pc_q, fl_q, wb_q;
  logic [2:0]          wba_q, ff_q;
  logic [31:0]         data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         lo_q;

  logic                wb_out_q, flags_load_q, pc_load_q, err_q;
  logic [2:0]          wba_out_q, flags_q;
  logic [15:0]         wb_data_q;
  logic [31:0]         pc_mem_q;

  logic                pending, beat_hi, last_beat, done, tmo;
  logic                cur_rd, cur_we, cur_pc, cur_fl, cur_wb;
  logic [2:0]          cur_wba, cur_ff;
  logic [31:0]         cur_data;
  logic [ADDR_W-1:0]   beat_addr;
  logic [15:0]         beat_wdata;

  logic                unused_ok;
  assign unused_ok = ^{JWSP, Address[31:ADDR_W]};

  always_comb begin
    pending   = 1'b1;
    beat_hi   = 1'b0;
    cur_rd    = rd_q;
    cur_we    = we_q;
    cur_pc    = pc_q;
    cur_fl    = fl_q;
    cur_wb    = wb_q;
    cur_wba   = wba_q;
    cur_ff    = ff_q;
    cur_data  = data_q;
    beat_addr = addr_q;
    case (state_q)
      IDLE: begin
        pending   = MR | MW;
        cur_rd    = MR;
        cur_we    = MW & ~MR;
        cur_pc    = Stack_PC;
        cur_fl    = Stack_Flags & ~Stack_PC;
        cur_wb    = WB;
        cur_wba   = WB_Address;
        cur_ff    = Final_Flags;
        cur_data  = Data;
        beat_addr = Address[ADDR_W-1:0];
      end
      BEAT1: begin
        beat_hi   = 1'b1;
        beat_addr = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    if (beat_hi)
      beat_wdata = cur_data[31:16];
    else if (cur_fl && cur_we)
      beat_wdata = {13'b0, cur_ff};
    else
      beat_wdata = cur_data[15:0];
  end

  assign last_beat = beat_hi | ~cur_pc;
  assign done      = pending & mem_ready & last_beat;
  assign tmo       = pending & ~mem_ready & (cnt_q == CW'(TIMEOUT - 1));

  assign mem_req   = pending & ~rst;
  assign mem_we    = mem_req & cur_we;
  assign mem_addr  = mem_req ? beat_addr : '0;
  assign mem_wdata = mem_req ? beat_wdata : '0;
  // An aborted access also releases Stall so the same instruction is not reissued.
  assign Stall     = pending & ~done & ~tmo & ~rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (pending) begin
      if (done || tmo) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (mem_ready) begin
        state_d = BEAT1;
        cnt_d   = '0;
      end else begin
        state_d = (state_q == IDLE) ? BEAT0 : state_q;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      we_q         <= 1'b0;
      pc_q         <= 1'b0;
      fl_q         <= 1'b0;
      wb_q         <= 1'b0;
      wba_q        <= '0;
      ff_q         <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      lo_q         <= '0;
      wb_out_q     <= 1'b0;
      wba_out_q    <= '0;
      wb_data_q    <= '0;
      flags_q      <= '0;
      flags_load_q <= 1'b0;
      pc_mem_q     <= '0;
      pc_load_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_out_q     <= 1'b0;
      flags_load_q <= 1'b0;
      pc_load_q    <= 1'b0;
      if (!pending) begin
        wb_out_q  <= WB;
        wba_out_q <= WB_Address;
        wb_data_q <= Data[15:0];
      end else if (done) begin
        wb_out_q  <= cur_wb & ~(cur_fl & cur_rd);
        wba_out_q <= cur_wba;
        wb_data_q <= cur_rd ? mem_rdata : cur_data[15:0];
        if (cur_pc && cur_rd) begin
          pc_mem_q  <= {mem_rdata, lo_q};
          pc_load_q <= 1'b1;
        end
        if (cur_fl && cur_rd) begin
          flags_q      <= mem_rdata[2:0];
          flags_load_q <= 1'b1;
        end
      end else if (tmo) begin
        err_q <= 1'b1;
      end else begin
        rd_q   <= cur_rd;
        we_q   <= cur_we;
        pc_q   <= cur_pc;
        fl_q   <= cur_fl;
        wb_q   <= cur_wb;
        wba_q  <= cur_wba;
        ff_q   <= cur_ff;
        data_q <= cur_data;
        if (state_q == IDLE)
          addr_q <= beat_addr;
        if (mem_ready)
          lo_q <= mem_rdata;
      end
    end
  end

  assign WB_Out            = wb_out_q;
  assign WB_Address_Out    = wba_out_q;
  assign WB_Data           = wb_data_q;
  assign Flags_From_Memory = flags_q;
  assign Flags_Load        = flags_load_q;
  assign PC_From_Memory    = pc_mem_q;
  assign PC_Load           = pc_load_q;
  assign Mem_Error         = err_q;

endmodule
